cdce_multi_ctrl: RTL and testbench

CDCE_MULTI_CTRL -- requirements
Module: cdce_multi_ctrl

---
 rtl/cdce_multi_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cdce_multi_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdce_multi_ctrl.sv
// Sequencer for several clock-synthesizer devices: issues config/powerdown/wakeup
// start pulses one device at a time, waits for lock after config, retries, and watches for lock loss.

module cdce_lock_mon (
  input  logic clk,
  input  logic rst_n,
  input  logic arm_set,
  input  logic arm_clr,
  input  logic lost_clr,
  input  logic svc,
  input  logic lock,
  output logic lost
);
  logic armed_q, armed_d, lost_q, lost_d;

  always_comb begin
    armed_d = (armed_q | arm_set) & ~arm_clr;
    // A device under service may legitimately drop lock; only idle devices are watched.
    lost_d  = (lost_q | (armed_q & ~lock & ~svc)) & ~lost_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      lost_q  <= lost_d;
    end
  end

  assign lost = lost_q;
endmodule

module cdce_multi_ctrl #(
  parameter int NUM_DEV   = 2,
  parameter int TIMER_W   = 12,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               i_config,
  input  logic               i_powerdown,
  input  logic               i_wakeup,
  input  logic [NUM_DEV-1:0] i_dev_mask,
  output logic               o_busy,
  output logic               o_ack,
  output logic               o_err,
  output logic [NUM_DEV-1:0] o_fail_mask,
  output logic [NUM_DEV-1:0] o_dev_config,
  output logic [NUM_DEV-1:0] o_dev_sleep,
  output logic [NUM_DEV-1:0] o_dev_wakeup,
  input  logic [NUM_DEV-1:0] i_dev_tran_busy,
  input  logic [NUM_DEV-1:0] i_dev_pll_lock,
  output logic [NUM_DEV-1:0] o_lock_lost
);
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [NUM_DEV-1:0] D_ONE = 1;
  localparam logic [TIMER_W-1:0] T_ONE = 1;
  localparam logic [RW-1:0]      R_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_DONE, S_CHECK, S_NEXT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_CFG, OP_PD, OP_WK} op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [NUM_DEV-1:0] pend_q, pend_d;
  logic [NUM_DEV-1:0] fail_q, fail_d;
  logic [NUM_DEV-1:0] busy_prev_q, busy_prev_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RW-1:0]      retry_q, retry_d;

  logic [NUM_DEV-1:0] cur_oh, svc, arm_set, arm_clr, lost_clr, rest;
  logic               one_req, lock_cur, fall_cur;

  always_comb begin
    // Two's-complement trick isolates the lowest pending device.
    cur_oh   = pend_q & (~pend_q + D_ONE);
    rest     = pend_q & ~cur_oh;
    one_req  = (i_config ^ i_powerdown ^ i_wakeup) & ~(i_config & i_powerdown & i_wakeup);
    lock_cur = |(cur_oh & i_dev_pll_lock);
    fall_cur = |(cur_oh & busy_prev_q & ~i_dev_tran_busy);

    state_d      = state_q;
    op_d         = op_q;
    pend_d       = pend_q;
    fail_d       = fail_q;
    busy_prev_d  = i_dev_tran_busy;
    timer_d      = timer_q;
    retry_d      = retry_q;
    arm_set      = '0;
    arm_clr      = '0;
    lost_clr     = '0;
    svc          = '0;
    o_ack        = 1'b0;
    o_err        = 1'b0;
    o_dev_config = '0;
    o_dev_sleep  = '0;
    o_dev_wakeup = '0;

    case (state_q)
      S_IDLE: begin
        if (one_req && (i_dev_mask != '0)) begin
          op_d    = i_config ? OP_CFG : (i_powerdown ? OP_PD : OP_WK);
          pend_d  = i_dev_mask;
          fail_d  = '0;
          retry_d = '0;
          state_d = S_START;
          if (i_config) lost_clr = i_dev_mask;
        end
      end
      S_START: begin
        svc     = cur_oh;
        timer_d = '1;
        case (op_q)
          OP_CFG:  o_dev_config = cur_oh;
          OP_PD:   begin o_dev_sleep = cur_oh; arm_clr = cur_oh; end
          default: o_dev_wakeup = cur_oh;
        endcase
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        svc     = cur_oh;
        timer_d = '1;
        if (fall_cur) state_d = (op_q == OP_CFG) ? S_CHECK : S_NEXT;
      end
      S_CHECK: begin
        svc = cur_oh;
        if (clk_en && (timer_q != '0)) timer_d = timer_q - T_ONE;
        if (lock_cur) begin
          arm_set = cur_oh;
          state_d = S_NEXT;
        end else if (timer_q == '0) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + R_ONE;
            state_d = S_START;
          end else begin
            fail_d  = fail_q | cur_oh;
            arm_clr = cur_oh;
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        svc     = cur_oh;
        pend_d  = rest;
        retry_d = '0;
        state_d = (rest != '0) ? S_START : S_DONE;
      end
      S_DONE: begin
        o_ack   = 1'b1;
        o_err   = |fail_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_CFG;
      pend_q      <= '0;
      fail_q      <= '0;
      busy_prev_q <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pend_q      <= pend_d;
      fail_q      <= fail_d;
      busy_prev_q <= busy_prev_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
    end
  end

  cdce_lock_mon u_mon [NUM_DEV-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm_set  (arm_set),
    .arm_clr  (arm_clr),
    .lost_clr (lost_clr),
    .svc      (svc),
    .lock     (i_dev_pll_lock),
    .lost     (o_lock_lost)
  );

  assign o_busy      = (state_q != S_IDLE);
  assign o_fail_mask = fail_q;
endmodule

// File: tb/tb_cdce_multi_ctrl.sv
// Bench for cdce_multi_ctrl: emulated serial engines/PLLs plus an op-level reference model.

module tb_cdce_multi_ctrl;
  localparam int ND = 2;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en;
  logic          i_config = 1'b0, i_powerdown = 1'b0, i_wakeup = 1'b0;
  logic [ND-1:0] i_dev_mask = '0;
  logic          o_busy, o_ack, o_err;
  logic [ND-1:0] o_fail_mask, o_dev_config, o_dev_sleep, o_dev_wakeup;
  logic [ND-1:0] i_dev_tran_busy, i_dev_pll_lock, o_lock_lost;

  logic [ND-1:0] emu_busy, emu_lock, glitch = '0;
  int            bcnt [ND];
  int            lcnt [ND];
  int            att  [ND];
  int            nfail[ND];
  int            plog[$];
  int            busy_len = 1, lock_dly = 0;
  logic          en_rand = 1'b0;
  logic [ND-1:0] arm_m = '0, lost_m = '0;
  int            n_chk = 0, n_err = 0;

  assign i_dev_tran_busy = emu_busy;
  assign i_dev_pll_lock  = emu_lock & ~glitch;

  cdce_multi_ctrl #(.NUM_DEV(ND), .TIMER_W(4), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_config(i_config), .i_powerdown(i_powerdown), .i_wakeup(i_wakeup),
    .i_dev_mask(i_dev_mask), .o_busy(o_busy), .o_ack(o_ack), .o_err(o_err),
    .o_fail_mask(o_fail_mask), .o_dev_config(o_dev_config), .o_dev_sleep(o_dev_sleep),
    .o_dev_wakeup(o_dev_wakeup), .i_dev_tran_busy(i_dev_tran_busy),
    .i_dev_pll_lock(i_dev_pll_lock), .o_lock_lost(o_lock_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk); #1;
      clk_en = en_rand ? (($urandom % 4) != 0) : 1'b1;
    end
  end

  // Engine/PLL emulation: busy for busy_len cycles from the pulse; lock rises lock_dly
  // cycles after busy drops unless this device is set to fail the current attempt.
  initial begin
    emu_busy = '0;
    emu_lock = '0;
    for (int i = 0; i < ND; i++) begin bcnt[i] = 0; lcnt[i] = -1; att[i] = 0; end
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        emu_busy = '0;
        for (int i = 0; i < ND; i++) begin bcnt[i] = 0; lcnt[i] = -1; att[i] = 0; end
      end else begin
        if (!o_busy) for (int i = 0; i < ND; i++) att[i] = 0;
        for (int i = 0; i < ND; i++) begin
          if (bcnt[i] > 0) begin
            bcnt[i]--;
            if (bcnt[i] == 0) emu_busy[i] = 1'b0;
          end
          if (lcnt[i] > 0) begin
            lcnt[i]--;
            if (lcnt[i] == 0) begin emu_lock[i] = 1'b1; lcnt[i] = -1; end
          end
        end
        if ($countones({o_dev_wakeup, o_dev_sleep, o_dev_config}) > 1) plog.push_back(99);
        else for (int i = 0; i < ND; i++) begin
          if (o_dev_config[i]) begin
            plog.push_back(i);
            emu_busy[i] = 1'b1; bcnt[i] = busy_len; emu_lock[i] = 1'b0;
            lcnt[i] = (att[i] >= nfail[i]) ? busy_len + lock_dly : -1;
            att[i]++;
          end
          if (o_dev_sleep[i]) begin
            plog.push_back(8 + i);
            emu_busy[i] = 1'b1; bcnt[i] = busy_len; emu_lock[i] = 1'b0; lcnt[i] = -1;
          end
          if (o_dev_wakeup[i]) begin
            plog.push_back(16 + i);
            emu_busy[i] = 1'b1; bcnt[i] = busy_len;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // op: 0 config, 1 powerdown, 2 wakeup
  task automatic run_op(input int op, input logic [ND-1:0] mask, input int b, input int l,
                        input int f0, input int f1, input bit intrude);
    int   expq[$];
    logic [ND-1:0] efail;
    int   base, n, acks, got_err, got_fm;
    bit   got;
    busy_len = b; lock_dly = l; nfail[0] = f0; nfail[1] = f1;
    efail = '0;
    for (int d = 0; d < ND; d++) if (mask[d]) begin
      if (op == 0) begin
        int tries = (nfail[d] > MR) ? MR + 1 : nfail[d] + 1;
        repeat (tries) expq.push_back(d);
        if (nfail[d] > MR) efail[d] = 1'b1;
      end else expq.push_back(op * 8 + d);
    end
    base = plog.size();
    @(posedge clk); #1;
    i_dev_mask = mask;
    i_config = (op == 0); i_powerdown = (op == 1); i_wakeup = (op == 2);
    if (op == 0) lost_m &= ~mask;
    @(posedge clk); #1;
    i_config = 1'b0; i_powerdown = 1'b0; i_wakeup = 1'b0;
    n = 0; acks = 0; got = 1'b0; got_err = 0; got_fm = 0;
    while (n < 3000 && !got) begin
      @(negedge clk);
      if (intrude && n == 2) begin i_powerdown = 1'b1; i_dev_mask = 2'b11; end
      if (intrude && n == 3) i_powerdown = 1'b0;
      if (o_ack) begin got = 1'b1; got_err = o_err; got_fm = o_fail_mask; end
      else n++;
    end
    chk("ack_seen", got, 1);
    if (op != 0) chk("pdwk_latency", n, $countones(mask) * (b + 2));
    chk("err", got_err, (efail != '0));
    chk("fail_mask", got_fm, efail);
    @(negedge clk);
    chk("ack_once", o_ack, 0);
    chk("idle_after", o_busy, 0);
    chk("npulse", plog.size() - base, expq.size());
    for (int i = 0; i < expq.size() && base + i < plog.size(); i++)
      chk("pulse", plog[base + i], expq[i]);
    for (int d = 0; d < ND; d++) if (mask[d]) begin
      if (op == 0) arm_m[d] = !efail[d];
      else if (op == 1) arm_m[d] = 1'b0;
    end
    chk("lock_lost", o_lock_lost, lost_m);
  endtask

  task automatic do_glitch(input logic [ND-1:0] m);
    @(posedge clk); #1;
    glitch = m;
    @(posedge clk); #1;
    glitch = '0;
    lost_m |= arm_m & m;
    @(negedge clk);
    chk("lost_glitch", o_lock_lost, lost_m);
  endtask

  task automatic bad_req(input logic c, input logic p, input logic w, input logic [ND-1:0] m);
    int base, busy_seen, ack_seen;
    base = plog.size();
    busy_seen = 0; ack_seen = 0;
    @(posedge clk); #1;
    i_config = c; i_powerdown = p; i_wakeup = w; i_dev_mask = m;
    @(posedge clk); #1;
    i_config = 1'b0; i_powerdown = 1'b0; i_wakeup = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_busy) busy_seen++;
      if (o_ack) ack_seen++;
    end
    chk("bad_busy", busy_seen, 0);
    chk("bad_ack", ack_seen, 0);
    chk("bad_pulses", plog.size() - base, 0);
  endtask

  initial begin
    int base, busy_seen, ack_seen;
    nfail[0] = 0; nfail[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_ack", {o_ack, o_err}, 0);
    chk("rst_fail", o_fail_mask, 0);
    chk("rst_lost", o_lock_lost, 0);
    chk("rst_pulses", {o_dev_config, o_dev_sleep, o_dev_wakeup}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(0, 2'b11, 5, 5, 0, 0, 1'b0);
    do_glitch(2'b10);
    run_op(2, 2'b01, 2, 0, 0, 0, 1'b0);
    run_op(0, 2'b10, 3, 4, 0, 0, 1'b0);
    run_op(0, 2'b01, 3, 2, 9, 0, 1'b0);
    run_op(0, 2'b11, 2, 1, 2, 1, 1'b0);
    bad_req(1'b1, 1'b1, 1'b0, 2'b11);
    bad_req(1'b1, 1'b0, 1'b0, 2'b00);
    bad_req(1'b1, 1'b1, 1'b1, 2'b01);
    bad_req(1'b0, 1'b1, 1'b1, 2'b10);
    run_op(0, 2'b11, 4, 3, 0, 0, 1'b1);
    run_op(1, 2'b11, 1, 0, 0, 0, 1'b0);

    // Reset while dev0 is in WAIT_DONE.
    busy_len = 8; lock_dly = 2; nfail[0] = 0; nfail[1] = 0;
    @(posedge clk); #1;
    i_config = 1'b1; i_dev_mask = 2'b01;
    @(posedge clk); #1;
    i_config = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_pulses", {o_dev_config, o_dev_sleep, o_dev_wakeup}, 0);
    chk("mid_rst_ack", {o_ack, o_err, o_fail_mask, o_lock_lost}, 0);
    arm_m = '0; lost_m = '0;
    base = plog.size();
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy_seen = 0; ack_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy) busy_seen++;
      if (o_ack) ack_seen++;
    end
    chk("post_rst_ack", ack_seen, 0);
    chk("post_rst_busy", busy_seen, 0);
    chk("post_rst_pulses", plog.size() - base, 0);
    run_op(2, 2'b11, 3, 0, 0, 0, 1'b0);

    en_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int op, b, l, f0, f1;
      logic [ND-1:0] m;
      op = $urandom % 3;
      m  = 2'($urandom_range(1, 3));
      b  = $urandom_range(1, 6);
      l  = $urandom_range(0, 10);
      f0 = (($urandom % 4) == 0) ? $urandom_range(1, 5) : 0;
      f1 = (($urandom % 4) == 0) ? $urandom_range(1, 5) : 0;
      run_op(op, m, b, l, f0, f1, 1'b0);
      if (($urandom % 3) == 0) do_glitch(2'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
